adder_bist_driver_64u: RTL and testbench

//  Self-test driver/checker for the registered 64-bit prefix-adder wrappers: drives operand

---
 rtl/adder_bist_driver_64u.sv | 162 ++++++++++++++++
 tb/tb_adder_bist_driver_64u.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/adder_bist_driver_64u.sv
// Self-test driver/checker for a registered 64-bit adder wrapper: issues corner and LFSR
// operand pairs, tracks expected sums through a LATENCY-deep pipe and tallies mismatches.
module adder_bist_driver_64u #(
  parameter int          NUM_VECTORS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] SEED_A      = 64'h0123456789ABCDEF,
  parameter logic [63:0] SEED_B      = 64'hFEDCBA9876543210
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] dut_a,
  output logic [63:0] dut_b,
  input  logic [63:0] dut_sum,
  input  logic        dut_cout,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx,
  output logic [15:0] vec_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [63:0] SEED_A_EFF = (SEED_A == 64'd0) ? 64'd1 : SEED_A;
  localparam logic [63:0] SEED_B_EFF = (SEED_B == 64'd0) ? 64'd1 : SEED_B;
  // Right-shifting Galois form of x^64+x^63+x^61+x^60+1
  localparam logic [63:0] LFSR_MASK  = 64'hD800_0000_0000_0000;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(LATENCY - 1);

  logic [1:0]  state_reg;
  logic [63:0] lfsr_a_reg, lfsr_b_reg;
  logic [15:0] drain_cnt_reg;

  logic        pipe_valid_reg [LATENCY];
  logic [15:0] pipe_idx_reg   [LATENCY];
  logic [64:0] pipe_exp_reg   [LATENCY];

  logic [63:0] vec_a, vec_b;
  logic [64:0] vec_exp;
  logic        issue, run_entry, mismatch;
  logic [15:0] err_next, first_next;

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

  always_comb begin
    vec_a = lfsr_a_reg;
    vec_b = lfsr_b_reg;
    case (vec_count)
      16'd0: begin vec_a = 64'd0; vec_b = 64'd0; end
      16'd1: begin vec_a = '1;    vec_b = 64'd1; end
      16'd2: begin vec_a = '1;    vec_b = '1;    end
      16'd3: begin vec_a = 64'h5555_5555_5555_5555; vec_b = 64'hAAAA_AAAA_AAAA_AAAA; end
      default: ;
    endcase
    vec_exp = {1'b0, vec_a} + {1'b0, vec_b};
  end

  assign issue     = (state_reg == RUN);
  assign run_entry = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign mismatch  = pipe_valid_reg[LATENCY-1] &&
                     ({dut_cout, dut_sum} != pipe_exp_reg[LATENCY-1]);

  always_comb begin
    err_next   = err_count;
    first_next = first_err_idx;
    if (mismatch) begin
      if (err_count != 16'hFFFF) err_next = err_count + 16'd1;
      if (first_err_idx == 16'hFFFF) first_next = pipe_idx_reg[LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      dut_a         <= '0;
      dut_b         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= 16'hFFFF;
      vec_count     <= '0;
      lfsr_a_reg    <= SEED_A_EFF;
      lfsr_b_reg    <= SEED_B_EFF;
      drain_cnt_reg <= '0;
    end else if (run_entry) begin
      state_reg     <= RUN;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= 16'hFFFF;
      vec_count     <= '0;
      lfsr_a_reg    <= SEED_A_EFF;
      lfsr_b_reg    <= SEED_B_EFF;
    end else begin
      err_count     <= err_next;
      first_err_idx <= first_next;
      case (state_reg)
        RUN: begin
          dut_a     <= vec_a;
          dut_b     <= vec_b;
          vec_count <= vec_count + 16'd1;
          if (vec_count >= 16'd4) begin
            lfsr_a_reg <= lfsr_step(lfsr_a_reg);
            lfsr_b_reg <= lfsr_step(lfsr_b_reg);
          end
          if (vec_count == LAST_IDX) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= '0;
          end
        end
        DRAIN: begin
          drain_cnt_reg <= drain_cnt_reg + 16'd1;
          if (drain_cnt_reg == DRAIN_LAST) begin
            // The last vector's compare lands on this same edge, so use err_next.
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_next == 16'd0);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_reg[0] <= 1'b0;
      pipe_idx_reg[0]   <= '0;
      pipe_exp_reg[0]   <= '0;
    end else begin
      pipe_valid_reg[0] <= issue;
      pipe_idx_reg[0]   <= vec_count;
      pipe_exp_reg[0]   <= vec_exp;
    end
  end

  for (genvar gi = 1; gi < LATENCY; gi++) begin : g_pipe
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid_reg[gi] <= 1'b0;
        pipe_idx_reg[gi]   <= '0;
        pipe_exp_reg[gi]   <= '0;
      end else begin
        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
        pipe_idx_reg[gi]   <= pipe_idx_reg[gi-1];
        pipe_exp_reg[gi]   <= pipe_exp_reg[gi-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_bist_driver_64u.sv
// Bench for adder_bist_driver_64u: a behavioural registered adder with selectable faults sits
// beside the driver; issued operands are scoreboarded and run results checked.
module tb_adder_bist_driver_64u;

  localparam int          NV     = 16;
  localparam int          LAT    = 2;
  localparam logic [63:0] SEED_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] SEED_B = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] dut_a, dut_b, dut_sum;
  logic        dut_cout;
  logic        busy, done, pass;
  logic [15:0] err_count, first_err_idx, vec_count;

  int checks = 0;
  int errors = 0;
  int mode = 0;  // 0 ideal, 1 cout forced low on a=all-ones,b=1, 2 output stuck at zero
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  adder_bist_driver_64u #(
    .NUM_VECTORS(NV), .LATENCY(LAT), .SEED_A(SEED_A), .SEED_B(SEED_B)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum), .dut_cout(dut_cout),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .vec_count(vec_count)
  );

  // Adder wrapper stand-in: one output register, giving LAT=2 edges from operand drive.
  always @(posedge clk) begin
    logic [64:0] s;
    s = {1'b0, dut_a} + {1'b0, dut_b};
    if (mode == 1 && dut_a == {64{1'b1}} && dut_b == 64'd1) s[64] = 1'b0;
    if (mode == 2) s = '0;
    {dut_cout, dut_sum} <= s;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] n;
    n = {1'b0, s[63:1]};
    if (s[0]) n = n ^ {1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 59'd0};
    return n;
  endfunction

  task automatic load_expected();
    logic [63:0] la, lb;
    la = SEED_A;
    lb = SEED_B;
    exp_q.delete();
    for (int i = 0; i < NV; i++) begin
      case (i)
        0: exp_q.push_back({64'd0, 64'd0});
        1: exp_q.push_back({{64{1'b1}}, 64'd1});
        2: exp_q.push_back({{64{1'b1}}, {64{1'b1}}});
        3: exp_q.push_back({{32{2'b01}}, {32{2'b10}}});
        default: begin
          exp_q.push_back({la, lb});
          la = lfsr_next(la);
          lb = lfsr_next(lb);
        end
      endcase
    end
  endtask

  task automatic run_vectors(input int fault, input bit poke,
                             input logic [15:0] exp_err, input logic [15:0] exp_first);
    int busy_cycles;
    logic [127:0] v;
    mode = fault;
    load_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
      v = exp_q.pop_front();
      check($sformatf("vec%0d_ab", i), {dut_a, dut_b}, v);
      $display("vec %0d a=%h b=%h", i, dut_a, dut_b);
      if (poke && (i == 4 || i == 15)) start = 1'b1;
    end
    for (int w = 0; w < 40 && !done; w++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cycles++;
    end
    check("done", 128'(done), 128'(1));
    check("busy_cycles", 128'(busy_cycles), 128'(NV + LAT));
    check("busy_low", 128'(busy), 128'(0));
    check("pass", 128'(pass), 128'(exp_err == 16'd0));
    check("err_count", 128'(err_count), 128'(exp_err));
    check("first_err_idx", 128'(first_err_idx), 128'(exp_first));
    check("vec_count", 128'(vec_count), 128'(NV));
    $display("run mode=%0d err=%0d first=%h pass=%0b", fault, err_count, first_err_idx, pass);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_pass", 128'(pass), 128'(0));
    check("rst_err", 128'(err_count), 128'(0));
    check("rst_first", 128'(first_err_idx), 128'(16'hFFFF));
    check("rst_vec", 128'(vec_count), 128'(0));
    check("rst_ab", {dut_a, dut_b}, 128'(0));
    rst = 1'b0;
    @(negedge clk);

    run_vectors(0, 1'b0, 16'd0, 16'hFFFF);        // ideal adder, corners included
    run_vectors(1, 1'b0, 16'd1, 16'd1);           // carry-only fault on idx1
    run_vectors(2, 1'b0, 16'(NV - 1), 16'd1);     // stuck output; idx0 still matches

    // Reset mid-run: no stale compare may follow release.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_vec_before_rst", 128'(vec_count), 128'(7));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_vec", 128'(vec_count), 128'(0));
    check("mid_rst_ab", {dut_a, dut_b}, 128'(0));
    check("mid_rst_first", 128'(first_err_idx), 128'(16'hFFFF));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_err", 128'(err_count), 128'(0));
    check("post_rst_done", 128'(done), 128'(0));
    check("post_rst_busy", 128'(busy), 128'(0));
    run_vectors(0, 1'b0, 16'd0, 16'hFFFF);

    // start pulses while busy are ignored; restart from DONE reissues the same sequence.
    run_vectors(0, 1'b1, 16'd0, 16'hFFFF);
    run_vectors(0, 1'b0, 16'd0, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
